// File: rtl/keypad_scan_reader.sv
// 4x4 keypad scanner: rotates an active-low column strobe, samples the synchronized rows
// at the end of each column period, and debounces whole frames into one-shot key events.
module keypad_scan_reader #(
    parameter int CLK_FREQ        = 1_000,
    parameter int SCAN_HZ         = 50,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int DEN     = SCAN_HZ * 4;
    localparam int COL_RAW = (DEN == 0) ? 1 : (CLK_FREQ + DEN - 1) / DEN;
    localparam int COL_CNT = (COL_RAW < 1) ? 1 : COL_RAW;
    localparam int CNT_W   = (COL_CNT > 1) ? $clog2(COL_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COL_CNT - 1);
    localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_FRAMES);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    // Key count is only needed as none / one / many, so it saturates at 2.
    function automatic logic [1:0] sat_count(input logic [1:0] acc, input logic [2:0] add);
        logic [3:0] sum;
        sum = {2'b00, acc} + {1'b0, add};
        return (sum >= 4'd2) ? 2'd2 : sum[1:0];
    endfunction

    logic [3:0]       row_p0, row_p1;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       col_idx;
    logic [1:0]       acc_n;
    logic [3:0]       acc_code;
    logic [2:0]       samp_n;
    logic [3:0]       samp_code;
    logic [1:0]       frame_n;
    logic [3:0]       frame_code;
    logic [1:0]       state;
    logic [3:0]       dcnt;
    logic [3:0]       dcnt_inc;
    logic [3:0]       cand;
    logic             sample;
    logic             frame_end;

    // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= 4'b1111;
            row_p1 <= 4'b1111;
        end else begin
            row_p0 <= key_row;
            row_p1 <= row_p0;
        end
    end

    assign sample    = (cnt == CNT_LAST);
    assign frame_end = sample && (col_idx == 2'd3);
    assign key_col   = ~(4'b0001 << col_idx);
    assign dcnt_inc  = dcnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            col_idx <= 2'd0;
        end else if (sample) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        samp_n    = 3'd0;
        samp_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_p1[r]) begin
                samp_n    = samp_n + 3'd1;
                samp_code = {2'(r), col_idx};
            end
        end
        frame_n    = sat_count(acc_n, samp_n);
        frame_code = (acc_n == 2'd0) ? samp_code : acc_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_n    <= 2'd0;
            acc_code <= 4'd0;
        end else if (frame_end) begin
            acc_n    <= 2'd0;
            acc_code <= 4'd0;
        end else if (sample) begin
            acc_n    <= frame_n;
            acc_code <= frame_code;
        end
    end

    // Debounce FSM: advances only on frame boundaries, so key_valid can fire once per frame at most
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dcnt      <= 4'd0;
            cand      <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (frame_n == 2'd1) begin
                            cand <= frame_code;
                            dcnt <= 4'd1;
                            if (DEB_N == 4'd1) begin
                                state     <= HELD;
                                key_code  <= frame_code;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                            end else begin
                                state <= DEB_PRESS;
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (frame_n != 2'd1) begin
                            state <= IDLE;
                        end else if (frame_code != cand) begin
                            cand <= frame_code;
                            dcnt <= 4'd1;
                        end else begin
                            dcnt <= dcnt_inc;
                            if (dcnt_inc == DEB_N) begin
                                state     <= HELD;
                                key_code  <= cand;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                            end
                        end
                    end
                    HELD: begin
                        if (frame_n == 2'd0) begin
                            dcnt <= 4'd1;
                            if (DEB_N == 4'd1) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state <= DEB_RELEASE;
                            end
                        end
                    end
                    default: begin
                        if (frame_n != 2'd0) begin
                            state <= HELD;
                        end else begin
                            dcnt <= dcnt_inc;
                            if (dcnt_inc == DEB_N) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_scan_reader.md
Name: keypad_scan_reader

Overview:
- Scans a 4x4 membrane keypad by driving one column low at a time and sampling the active-low row lines.
- Performs frame-level debounce with multi-key rejection, then reports each debounced press as a one-cycle event carrying a 4-bit key code.
- Input-side counterpart of the multiplexed FND scan driver; shares its timing derivation and board clock domain.
- Feeds key events to the speed/LCD control logic.

Parameters:
- CLK_FREQ, 1_000: clk frequency in Hz.
- SCAN_HZ, 50: full 4-column frame rate in Hz.
- DEBOUNCE_FRAMES, 3: consecutive identical frames required to confirm a press or a release. Legal range is 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- key_row  input  4  keypad rows, active-low with external pull-ups. Asynchronous to clk.
- key_col  output  4  column drive, one-hot active-low.
- key_valid  output  1  one-cycle pulse on a debounced press.
- key_code  output  4  code of the last confirmed key, equal to row*4 + col.
- key_held  output  1  high while the confirmed key is considered pressed.

Behaviour:
- Reset values: key_col=4'b1110, key_valid=0, key_code=0, key_held=0. All counters, the accumulator and the FSM clear; state is IDLE.
- Input sync: key_row passes through a 2-flop synchronizer. Its reset value is 4'b1111.
- Column timing: COL_CNT = ceil(CLK_FREQ/(SCAN_HZ*4)), forced to 1 if the denominator is 0.
  - cnt counts 0..COL_CNT-1.
  - At cnt==COL_CNT-1, col_idx advances, wrapping 3->0.
  - key_col = ~(1<<col_idx).
  - Defaults give COL_CNT=5, so a frame is 20 clk cycles.
- Sampling: the synchronized rows are sampled only on the cycle where cnt==COL_CNT-1, i.e. the last cycle of each column period. This gives settle time.
  - A low row r in column c marks key r*4+c.
  - The frame accumulator records the pressed-key count (saturating at 2) and the single key code.
- Frame end is the sample edge with col_idx==3. On that edge:
  - The frame result is computed from columns 0-2 plus the current sample: NONE, ONE(k) or MULTI.
  - The FSM updates on that same edge.
  - The accumulator clears for the next frame.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE. Counter dcnt is 4 bits. Transitions are evaluated at frame end only.
  - IDLE:
    - ONE(k): cand<=k, dcnt<=1, go to DEB_PRESS. If DEBOUNCE_FRAMES==1, go directly to HELD with a confirm.
    - NONE or MULTI: stay.
  - DEB_PRESS:
    - ONE(cand): dcnt++. When the new count equals DEBOUNCE_FRAMES, confirm.
    - ONE(k!=cand): cand<=k, dcnt<=1.
    - NONE or MULTI: go to IDLE.
  - Confirm: enter HELD, key_code<=cand, key_held<=1, key_valid=1 for exactly the next cycle.
  - HELD:
    - NONE: dcnt<=1, go to DEB_RELEASE. If DEBOUNCE_FRAMES==1, go directly to IDLE and set key_held<=0.
    - ONE or MULTI: stay. A second key or a rollover to another key never emits a new event.
  - DEB_RELEASE:
    - NONE: dcnt++. At DEBOUNCE_FRAMES, go to IDLE and set key_held<=0.
    - Any key: return to HELD with no new key_valid.
- key_code holds its last value after release and changes only on a confirm.
- key_valid is never high for two consecutive cycles, and fires at most once per frame.
- Reset mid-scan aborts immediately to the reset values. No key_valid is emitted on reset release, even if a key is down; a full debounce is required.

Test Plan (defaults CLK_FREQ=1000, SCAN_HZ=50, DEBOUNCE_FRAMES=3; a keypad model pulls row r low when column c is driven low and key (r,c) is closed):
- No key pressed for 200 cycles:
  - key_col rotates 1110->1101->1011->0111 every 5 cycles.
  - key_valid stays 0, key_held=0, key_code=0.
- Hold key row2/col1 continuously:
  - Exactly one key_valid pulse, one cycle after the 3rd consecutive frame end containing it.
  - key_code=9, key_held=1.
  - No further pulses while held for 10 frames.
- Release key 9 after confirm:
  - key_held falls at the 3rd consecutive empty frame end.
  - key_code stays 9.
- Bounce: key 5 present in frame 1, absent in frame 2, present in frames 3-5:
  - One pulse at the frame-5 end, with key_code=5.
  - A 2-frame release glitch while HELD returns to HELD with no new pulse.
- Keys 0 and 15 pressed together from IDLE:
  - No key_valid, key_held=0.
  - With key 3 held then key 12 added: no new event, key_code stays 3.
- Assert rst mid-frame while key 7 is held, then release rst:
  - Outputs return to the reset values immediately.
  - key_valid is re-emitted with key_code=7 only after 3 fresh full frames.
